// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store bridge to a word-only data memory.
//   clk, reset            : clock, synchronous active-high reset
//   req_*, funct3, addr   : core request (store when req_we), RV32I width code
//   wdata / rdata         : store data in, extended load data out
//   stall                 : held high during the read phase of SB/SH
//   misaligned, fault     : combinational request classification
//   err_sticky            : latched OR of misaligned|fault until reset
//   mem_*                 : word-addressed data memory port
module load_store_unit #(
   parameter int MEM_BYTES = 4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misaligned,
   output logic        fault,
   output logic        err_sticky,
   output logic        mem_WE,
   output logic [31:0] mem_Address,
   output logic [31:0] mem_WD,
   input  logic [31:0] mem_RD
);
   localparam logic [31:0] LAST = 32'(MEM_BYTES - 1);
   typedef enum logic {IDLE, RMW_WRITE} state_t;
   state_t      r_state;
   logic [31:0] r_merge, r_addr;
   logic        r_err;
   logic        w_idle, w_illegal, w_ok, w_start;
   logic [7:0]  w_b;
   logic [15:0] w_h;
   logic [31:0] w_ext, w_mask, w_ins;
   assign w_idle    = r_state == IDLE;
   assign w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (req_we && funct3[2]);
   assign misaligned = req_valid && ((funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00));
   assign fault     = req_valid && (w_illegal || addr > LAST);
   assign w_ok      = req_valid && !misaligned && !fault;
   // Byte and halfword lanes picked by shifting the addressed lane down to bit 0.
   assign w_b   = 8'(mem_RD >> {addr[1:0], 3'b000});
   assign w_h   = 16'(mem_RD >> {addr[1], 4'b0000});
   // funct3[2] marks the unsigned variants, which suppresses sign extension.
   assign w_ext = funct3[1] ? mem_RD
                : funct3[0] ? {{16{~funct3[2] & w_h[15]}}, w_h}
                : {{24{~funct3[2] & w_b[7]}}, w_b};
   assign rdata = (w_idle && w_ok && !req_we) ? w_ext : 32'h0;
   // Replicating the store data across lanes lets one mask select the target lane(s).
   assign w_mask = funct3[0] ? (32'h0000_FFFF << {addr[1], 4'b0000}) : (32'h0000_00FF << {addr[1:0], 3'b000});
   assign w_ins  = funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
   assign w_start = !reset && w_idle && w_ok && req_we && !funct3[1];
   assign stall       = w_start;
   assign mem_WE      = !reset && (w_idle ? (w_ok && req_we && funct3 == 3'b010) : 1'b1);
   assign mem_Address = w_idle ? {addr[31:2], 2'b00} : r_addr;
   assign mem_WD      = w_idle ? wdata : r_merge;
   assign err_sticky  = r_err;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_err   <= 1'b0;
      end else begin
         r_err   <= r_err || misaligned || fault;
         r_state <= w_start ? RMW_WRITE : IDLE;
         if (w_start) begin
            r_merge <= (mem_RD & ~w_mask) | (w_ins & w_mask);
            r_addr  <= {addr[31:2], 2'b00};
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [31:0] rdata, mem_Address, mem_WD, mem_RD;
   logic        stall, misaligned, fault, err_sticky, mem_WE;
   logic [31:0] mem [0:999];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_idx = 10'd0;
   logic [31:0] pl_dat = 32'h0;
   int          n_chk = 0, n_fail = 0;

   load_store_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
      .stall(stall), .misaligned(misaligned), .fault(fault),
      .err_sticky(err_sticky), .mem_WE(mem_WE), .mem_Address(mem_Address),
      .mem_WD(mem_WD), .mem_RD(mem_RD)
   );

   always #5 clk = ~clk;

   assign mem_RD = (mem_Address[31:2] < 30'd1000) ? mem[mem_Address[11:2]] : 32'h0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_dat;
      else if (mem_WE && mem_Address[31:2] < 30'd1000) mem[mem_Address[11:2]] <= mem_WD;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
      pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
      step();
      pl_en = 1'b0;
   endtask

   task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = d;
   endtask

   typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] exp;} ld_t;
   ld_t loads [6] = '{
      '{3'b000, 32'h1, 32'h0000_007F},
      '{3'b000, 32'h3, 32'hFFFF_FF80},
      '{3'b100, 32'h3, 32'h0000_0080},
      '{3'b001, 32'h2, 32'hFFFF_80FF},
      '{3'b101, 32'h2, 32'h0000_80FF},
      '{3'b010, 32'h0, 32'h80FF_7F01}
   };

   initial begin
      for (int i = 0; i < 1000; i++) preload(10'(i), 32'h0);
      preload(10'd0,   32'h80FF_7F01);
      preload(10'd4,   32'h1122_3344);
      preload(10'd5,   32'h0000_0000);
      preload(10'd1,   32'h5566_7788);
      preload(10'd999, 32'h0102_0304);
      req(1'b1, 3'b010, 32'h18, 32'h1234_5678);
      @(negedge clk);
      check("reset_we",    {31'h0, mem_WE}, 32'h0);
      check("reset_stall", {31'h0, stall}, 32'h0);
      check("reset_err",   {31'h0, err_sticky}, 32'h0);
      step();
      reset = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("idle_rdata", rdata, 32'h0);
      check("idle_we",    {31'h0, mem_WE}, 32'h0);
      step();

      foreach (loads[i]) begin
         req(1'b0, loads[i].f3, loads[i].a, 32'h0);
         @(negedge clk);
         check($sformatf("load%0d", i), rdata, loads[i].exp);
         check($sformatf("load%0d_stall", i), {31'h0, stall}, 32'h0);
         step();
      end

      req(1'b1, 3'b000, 32'h12, 32'h0000_00AB);
      @(negedge clk);
      check("sb_c0_stall", {31'h0, stall}, 32'h1);
      check("sb_c0_we",    {31'h0, mem_WE}, 32'h0);
      step();
      @(negedge clk);
      check("sb_c1_we",    {31'h0, mem_WE}, 32'h1);
      check("sb_c1_wd",    mem_WD, 32'h11AB_3344);
      check("sb_c1_addr",  mem_Address, 32'h10);
      check("sb_c1_stall", {31'h0, stall}, 32'h0);
      step();
      req(1'b0, 3'b010, 32'h10, 32'h0);
      @(negedge clk);
      check("sb_readback", rdata, 32'h11AB_3344);
      step();

      req(1'b1, 3'b001, 32'h16, 32'h0000_BEEF);
      @(negedge clk);
      check("sh_c0_stall", {31'h0, stall}, 32'h1);
      step();
      @(negedge clk);
      check("sh_c1_we", {31'h0, mem_WE}, 32'h1);
      check("sh_c1_wd", mem_WD, 32'hBEEF_0000);
      step();
      req(1'b0, 3'b010, 32'h14, 32'h0);
      @(negedge clk);
      check("sh_readback", rdata, 32'hBEEF_0000);
      step();

      req(1'b1, 3'b010, 32'h18, 32'hDEAD_BEEF);
      @(negedge clk);
      check("sw_we",    {31'h0, mem_WE}, 32'h1);
      check("sw_stall", {31'h0, stall}, 32'h0);
      check("sw_wd",    mem_WD, 32'hDEAD_BEEF);
      step();
      req(1'b0, 3'b010, 32'h18, 32'h0);
      @(negedge clk);
      check("sw_readback", rdata, 32'hDEAD_BEEF);
      check("err_clean",   {31'h0, err_sticky}, 32'h0);
      step();

      req(1'b0, 3'b010, 32'h2, 32'h0);
      @(negedge clk);
      check("lw_mis",       {31'h0, misaligned}, 32'h1);
      check("lw_mis_rdata", rdata, 32'h0);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check("err_set", {31'h0, err_sticky}, 32'h1);
      step();

      req(1'b1, 3'b001, 32'h5, 32'h0000_CAFE);
      @(negedge clk);
      check("sh_mis",       {31'h0, misaligned}, 32'h1);
      check("sh_mis_we",    {31'h0, mem_WE}, 32'h0);
      check("sh_mis_stall", {31'h0, stall}, 32'h0);
      step();

      req(1'b1, 3'b010, 32'd4000, 32'h1);
      @(negedge clk);
      check("sw_oob_fault", {31'h0, fault}, 32'h1);
      check("sw_oob_we",    {31'h0, mem_WE}, 32'h0);
      step();

      req(1'b0, 3'b011, 32'h0, 32'h0);
      @(negedge clk);
      check("ill_fault", {31'h0, fault}, 32'h1);
      check("ill_rdata", rdata, 32'h0);
      step();

      req(1'b1, 3'b000, 32'd3999, 32'h0000_005A);
      @(negedge clk);
      check("sb_top_fault", {31'h0, fault}, 32'h0);
      check("sb_top_stall", {31'h0, stall}, 32'h1);
      step();
      @(negedge clk);
      check("sb_top_we",   {31'h0, mem_WE}, 32'h1);
      check("sb_top_wd",   mem_WD, 32'h5A02_0304);
      check("sb_top_addr", mem_Address, 32'd3996);
      step();
      req(1'b0, 3'b010, 32'd3996, 32'h0);
      @(negedge clk);
      check("sb_top_readback", rdata, 32'h5A02_0304);
      step();

      req(1'b1, 3'b000, 32'h4, 32'h0000_0099);
      @(negedge clk);
      check("rst_rmw_c0_stall", {31'h0, stall}, 32'h1);
      step();
      reset = 1'b1;
      @(negedge clk);
      check("rst_rmw_we", {31'h0, mem_WE}, 32'h0);
      step();
      reset = 1'b0;
      req(1'b0, 3'b100, 32'h4, 32'h0);
      @(negedge clk);
      check("rst_err_clear", {31'h0, err_sticky}, 32'h0);
      check("rst_lbu",       rdata, 32'h0000_0088);
      check("rst_lbu_stall", {31'h0, stall}, 32'h0);
      check("rst_word_kept", mem[1], 32'h5566_7788);
      step();
      req_valid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I core datapath and the word-addressed data memory.
- Converts byte, halfword and word loads and stores into full-word memory accesses:
  - byte-lane extraction plus sign or zero extension for loads;
  - a two-cycle read-modify-write sequence for SB/SH, because the data memory writes whole words only.
- Flags misaligned, out-of-range and illegal accesses.
- Stalls the core while a read-modify-write is in flight.

Parameters:
- MEM_BYTES, 4000, byte size of the data memory (1000 words); accesses at or above this address are faults.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core issues a memory instruction this cycle
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result (combinational)
- stall  out  1  core must hold all req_* inputs stable and not advance PC
- misaligned  out  1  current request is misaligned (combinational)
- fault  out  1  current request is out of range or illegal (combinational)
- err_sticky  out  1  latched OR of misaligned|fault; cleared only by reset
- mem_WE  out  1  data memory write enable
- mem_Address  out  32  word-aligned byte address: {addr[31:2],2'b00}
- mem_WD  out  32  data memory write data
- mem_RD  in  32  data memory read data (combinational read)

Behaviour:
- FSM states: IDLE, RMW_WRITE. Reset forces IDLE on the next edge.
- While reset=1, mem_WE=0 and stall=0 combinationally, err_sticky is cleared, and rdata/misaligned/fault keep their combinational definitions.
- Classification of a request (req_valid=1):
  - illegal: funct3 ∈ {011,110,111}, or a store with funct3 ∈ {100,101}.
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - fault: illegal, or addr > MEM_BYTES-1.
  - A faulting or misaligned request never writes memory, and rdata=0.
- Loads (IDLE, single cycle, stall=0):
  - Lane selection: byte = mem_RD[8*addr[1:0] +: 8]; halfword = mem_RD[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes mem_RD unchanged.
- SW (IDLE, single cycle): mem_WE=1, mem_WD=wdata, stall=0. FSM stays in IDLE.
- SB/SH, cycle 0 (IDLE, legal request):
  - stall=1, mem_WE=0.
  - Register merge_word = mem_RD with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Other lanes are unchanged.
  - Latch the word address. Next state is RMW_WRITE.
- SB/SH, cycle 1 (RMW_WRITE):
  - mem_WE=1, mem_WD=merge_word, mem_Address=latched word address, stall=0.
  - Next state is IDLE unconditionally.
  - req_* inputs are ignored in this state, so the stalled instruction cannot retrigger.
- Total latency: SB/SH take 2 cycles; every other access takes 1 cycle.
- In IDLE with req_valid=0: mem_WE=0, stall=0, rdata=0.
- reset asserted in RMW_WRITE: no write occurs (mem_WE is gated by reset), and the next state is IDLE.
- err_sticky is set on the edge following any cycle with req_valid & (misaligned|fault).
- Address at the top boundary: addr=MEM_BYTES-1 is legal for bytes. The misaligned rule governs halfword and word accesses. MEM_BYTES and above is a fault.

Test Plan:
- Load extension: memory word 0 = 0x80FF_7F01. LB @0x1 → 0x0000_007F; LB @0x3 → 0xFFFF_FF80; LBU @0x3 → 0x0000_0080; LH @0x2 → 0xFFFF_80FF; LHU @0x2 → 0x0000_80FF; LW @0x0 → 0x80FF_7F01. stall=0 throughout.
- SB read-modify-write: word 0x10 = 0x1122_3344, SB @0x12 with wdata=0xAB. Expect:
  - cycle 0: stall=1, mem_WE=0;
  - cycle 1: mem_WE=1, mem_WD=0x11AB_3344, mem_Address=0x10, stall=0;
  - then IDLE; a subsequent LW @0x10 → 0x11AB_3344.
- SH and SW: SH @0x16 with wdata=0xBEEF onto word 0x0 at 0x14 → 0xBEEF_0000 after 2 cycles. SW @0x18 with 0xDEADBEEF → mem_WE=1 in the same cycle, no stall.
- Misaligned and fault: LW @0x2 → misaligned=1, rdata=0, err_sticky=1 next cycle. SH @0x5 → no write, no stall. SW @4000 → fault=1, mem_WE=0. funct3=011 load → fault=1. SB @3999 → normal 2-cycle write.
- Reset mid-RMW: assert reset during the RMW_WRITE cycle of an SB → mem_WE=0, target word unchanged, FSM in IDLE and err_sticky=0 after release, and the next LB completes in 1 cycle.
